// File: rtl/vga_rx_pkg.sv
// Shared constants and types for the VGA receive-side marker tracker.
package vga_rx_pkg;

  // 1280x1024@60 timing, measured from the sync rising edges.
  localparam logic [11:0] H_START      = 12'd360;
  localparam logic [11:0] FRAME_WIDTH  = 12'd1280;
  localparam logic [11:0] H_END        = H_START + FRAME_WIDTH;
  localparam logic [10:0] V_START      = 11'd41;
  localparam logic [10:0] FRAME_HEIGHT = 11'd1024;
  localparam logic [10:0] V_END        = V_START + FRAME_HEIGHT;

  // Red-marker colour window.
  localparam logic [3:0] RED_MIN = 4'hC;
  localparam logic [3:0] GB_MAX  = 4'h3;

  // Per-frame pixel counter.
  localparam int            CNT_W      = 21;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] MIN_PIXELS = 21'd16;

  typedef enum logic {
    SYNC_WAIT,
    TRACK
  } state_t;

endpackage

// File: rtl/vga_rx_timing.sv
// Input registers, sync edge detection and pixel coordinate recovery.
module vga_rx_timing
  import vga_rx_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  red_in,
  input  logic [3:0]  green_in,
  input  logic [3:0]  blue_in,
  output logic        active,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        frame_edge,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue
);

  logic        hs_r, hs_d, vs_r, vs_d;
  logic        hs_rise, vs_rise;
  logic [11:0] h_cnt;
  logic [10:0] v_cnt;

  // Register every input once; keep a delayed sync copy for edge detection.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_r  <= 1'b0;
      hs_d  <= 1'b0;
      vs_r  <= 1'b0;
      vs_d  <= 1'b0;
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else begin
      hs_r  <= hsync;
      hs_d  <= hs_r;
      vs_r  <= vsync;
      vs_d  <= vs_r;
      red   <= red_in;
      green <= green_in;
      blue  <= blue_in;
    end
  end

  assign hs_rise = hs_r & ~hs_d;
  assign vs_rise = vs_r & ~vs_d;

  // Horizontal and vertical position counters, both saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      if (hs_rise)
        h_cnt <= '0;
      else if (h_cnt != '1)
        h_cnt <= h_cnt + 12'd1;

      // Vsync takes priority so a coincident Hsync edge does not count a line.
      if (vs_rise)
        v_cnt <= '0;
      else if (hs_rise && (v_cnt != '1))
        v_cnt <= v_cnt + 11'd1;
    end
  end

  // Active-area window and zero-based pixel coordinates.
  always_comb begin
    active     = (h_cnt >= H_START) && (h_cnt < H_END) &&
                 (v_cnt >= V_START) && (v_cnt < V_END);
    x          = h_cnt - H_START;
    y          = {1'b0, v_cnt - V_START};
    frame_edge = vs_rise;
  end

endmodule

// File: rtl/vga_marker_tracker.sv
// Red-marker bounding-box tracker: classifies active pixels and publishes
// the box centre once per frame.
module vga_marker_tracker
  import vga_rx_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        Hsync,
  input  logic        Vsync,
  input  logic [3:0]  vgaRed,
  input  logic [3:0]  vgaGreen,
  input  logic [3:0]  vgaBlue,
  output logic [11:0] MarkerCoord_X,
  output logic [11:0] MarkerCoord_Y,
  output logic        marker_found,
  output logic        frame_done,
  output logic [20:0] pixel_count
);

  logic             active, frame_edge, match;
  logic [11:0]      x, y;
  logic [3:0]       red, green, blue;
  state_t           state, state_nxt;
  logic             publish, acc_en;
  logic [11:0]      min_x, max_x, min_y, max_y;
  logic [11:0]      min_x_n, max_x_n, min_y_n, max_y_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [12:0]      sum_x, sum_y;

  vga_rx_timing u_timing (
    .clk        (clk),
    .reset      (reset),
    .hsync      (Hsync),
    .vsync      (Vsync),
    .red_in     (vgaRed),
    .green_in   (vgaGreen),
    .blue_in    (vgaBlue),
    .active     (active),
    .x          (x),
    .y          (y),
    .frame_edge (frame_edge),
    .red        (red),
    .green      (green),
    .blue       (blue)
  );

  assign match = active && (red >= RED_MIN) && (green <= GB_MAX) && (blue <= GB_MAX);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= SYNC_WAIT;
    else       state <= state_nxt;
  end

  // Next state: the first Vsync edge after reset locks onto the stream.
  always_comb begin
    state_nxt = state;
    if ((state == SYNC_WAIT) && frame_edge)
      state_nxt = TRACK;
  end

  // FSM outputs: publish only on frame edges while tracking.
  always_comb begin
    publish = (state == TRACK) && frame_edge;
    acc_en  = (state == TRACK) && match;
  end

  // Accumulator next values; a match on the frame-end cycle is folded in here
  // so it belongs to the closing frame.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    min_x_n = min_x;
    max_x_n = max_x;
    min_y_n = min_y;
    max_y_n = max_y;
    cnt_n   = cnt;
    if (acc_en) begin
      if (x < min_x) min_x_n = x;
      if (x > max_x) max_x_n = x;
      if (y < min_y) min_y_n = y;
      if (y > max_y) max_y_n = y;
      if (cnt != CNT_MAX) cnt_n = cnt + 1'b1;
    end
    sum_x = {1'b0, min_x_n} + {1'b0, max_x_n};
    sum_y = {1'b0, min_y_n} + {1'b0, max_y_n};
  end

  // Per-frame accumulators, reinitialised on every frame edge.
  always_ff @(posedge clk) begin
    if (reset || frame_edge) begin
      min_x <= '1;
      min_y <= '1;
      max_x <= '0;
      max_y <= '0;
      cnt   <= '0;
    end else begin
      min_x <= min_x_n;
      min_y <= min_y_n;
      max_x <= max_x_n;
      max_y <= max_y_n;
      cnt   <= cnt_n;
    end
  end

  // Output registers updated at frame end; coordinates hold when no marker.
  always_ff @(posedge clk) begin
    if (reset) begin
      MarkerCoord_X <= '0;
      MarkerCoord_Y <= '0;
      marker_found  <= 1'b0;
      frame_done    <= 1'b0;
      pixel_count   <= '0;
    end else begin
      frame_done <= publish;
      if (publish) begin
        pixel_count <= cnt_n;
        if (cnt_n >= MIN_PIXELS) begin
          marker_found  <= 1'b1;
          MarkerCoord_X <= sum_x[12:1];
          MarkerCoord_Y <= sum_y[12:1];
        end else begin
          marker_found <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_marker_tracker.sv
// Directed testbench for vga_marker_tracker using shortened blanking lines.
module tb_vga_marker_tracker;

  logic        clk = 1'b0;
  logic        reset;
  logic        Hsync, Vsync;
  logic [3:0]  vgaRed, vgaGreen, vgaBlue;
  logic [11:0] MarkerCoord_X, MarkerCoord_Y;
  logic        marker_found, frame_done;
  logic [20:0] pixel_count;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fd_count  = 0;
  int line_no   = 0;

  always #5 clk = ~clk;

  vga_marker_tracker dut (
    .clk           (clk),
    .reset         (reset),
    .Hsync         (Hsync),
    .Vsync         (Vsync),
    .vgaRed        (vgaRed),
    .vgaGreen      (vgaGreen),
    .vgaBlue       (vgaBlue),
    .MarkerCoord_X (MarkerCoord_X),
    .MarkerCoord_Y (MarkerCoord_Y),
    .marker_found  (marker_found),
    .frame_done    (frame_done),
    .pixel_count   (pixel_count)
  );

  // Count frame_done pulses, sampled away from the active edge.
  always @(negedge clk) if (frame_done) fd_count++;

  // One line: Hsync pulse then colour c on X in [x0,x1]. Pin cycle idx
  // carries the pixel seen with h_cnt = idx-1.
  task automatic send_line(input int x0, input int x1, input logic [11:0] c, input int len);
    for (int idx = 0; idx < len; idx++) begin
      @(negedge clk);
      Hsync = (idx < 4);
      if ((idx - 1 >= 360 + x0) && (idx - 1 <= 360 + x1))
        {vgaRed, vgaGreen, vgaBlue} = c;
      else
        {vgaRed, vgaGreen, vgaBlue} = 12'h000;
    end
    @(negedge clk);
    Hsync = 1'b0;
    {vgaRed, vgaGreen, vgaBlue} = 12'h000;
    line_no++;
  endtask

  // Advance with short blank lines so the next line sent is active row yy.
  task automatic goto_row(input int yy);
    while (line_no < 41 + yy - 1) send_line(1, 0, 12'h000, 6);
  endtask

  task automatic put_pixel(input int xx, input int yy, input logic [11:0] c);
    goto_row(yy);
    send_line(xx, xx, c, 360 + xx + 3);
  endtask

  task automatic put_block(input int x0, input int x1, input int y0, input int y1,
                           input logic [11:0] c);
    for (int yy = y0; yy <= y1; yy++) begin
      goto_row(yy);
      send_line(x0, x1, c, 360 + x1 + 3);
    end
  endtask

  // Vsync pulse: ends the current frame and starts the next.
  task automatic close_frame();
    @(negedge clk);
    Vsync = 1'b1;
    repeat (4) @(negedge clk);
    Vsync = 1'b0;
    repeat (4) @(negedge clk);
    line_no = 0;
  endtask

  task automatic check_outputs(input string name, input int exp_fd, input logic exp_found,
                               input int exp_pc, input int exp_x, input int exp_y);
    total_cnt++;
    if (fd_count !== exp_fd)
      $display("FAIL %s frame_done pulses: got %0d expected %0d", name, fd_count, exp_fd);
    else pass_cnt++;
    total_cnt++;
    if (marker_found !== exp_found)
      $display("FAIL %s marker_found: got %0b expected %0b", name, marker_found, exp_found);
    else pass_cnt++;
    total_cnt++;
    if (pixel_count !== 21'(exp_pc))
      $display("FAIL %s pixel_count: got %0d expected %0d", name, pixel_count, exp_pc);
    else pass_cnt++;
    total_cnt++;
    if (MarkerCoord_X !== 12'(exp_x))
      $display("FAIL %s MarkerCoord_X: got %0d expected %0d", name, MarkerCoord_X, exp_x);
    else pass_cnt++;
    total_cnt++;
    if (MarkerCoord_Y !== 12'(exp_y))
      $display("FAIL %s MarkerCoord_Y: got %0d expected %0d", name, MarkerCoord_Y, exp_y);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    Hsync = 1'b0;
    Vsync = 1'b0;
    {vgaRed, vgaGreen, vgaBlue} = 12'h000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (frame_done !== 1'b0)
      $display("FAIL reset frame_done: got %0b expected 0", frame_done);
    else pass_cnt++;
    check_outputs("reset", 0, 1'b0, 0, 0, 0);
  endtask

  task automatic test_lock_and_empty();
    put_block(5, 8, 5, 8, 12'hF00);   // ignored: not yet locked
    close_frame();
    check_outputs("lock", 0, 1'b0, 0, 0, 0);
    close_frame();
    check_outputs("empty_frame", 1, 1'b0, 0, 0, 0);
  endtask

  task automatic test_block();
    put_block(100, 107, 200, 207, 12'hF00);
    close_frame();
    check_outputs("block_8x8", 2, 1'b1, 64, 103, 203);
  endtask

  task automatic test_small_block();
    put_block(10, 12, 10, 12, 12'hF00);
    close_frame();
    check_outputs("block_3x3", 3, 1'b0, 9, 103, 203);
  endtask

  task automatic test_boundaries();
    put_pixel(5, -1, 12'hF00);     // line before first active line
    put_pixel(5, 10, 12'hC30);     // window corner, counted
    put_pixel(5, 11, 12'hB00);     // red too low
    put_pixel(5, 12, 12'hC40);     // green too high
    put_pixel(5, 13, 12'hC04);     // blue too high
    put_pixel(-1, 14, 12'hF00);    // h_cnt = H_START-1
    put_pixel(1280, 15, 12'hF00);  // first pixel past active line
    put_pixel(1279, 1023, 12'hF00);// last active pixel, counted
    put_pixel(5, 1024, 12'hF00);   // first line past active frame
    close_frame();
    check_outputs("boundaries", 4, 1'b0, 2, 103, 203);
  endtask

  task automatic test_corners();
    put_block(0, 3, 0, 3, 12'hF00);
    close_frame();
    check_outputs("corner_left", 5, 1'b1, 16, 1, 1);
    put_block(1276, 1279, 0, 3, 12'hF00);
    close_frame();
    check_outputs("corner_right", 6, 1'b1, 16, 1277, 1);
  endtask

  task automatic test_reset_mid_frame();
    put_block(50, 57, 60, 67, 12'hF00);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    line_no = 0;
    check_outputs("mid_reset", 6, 1'b0, 0, 0, 0);
    put_block(20, 27, 20, 27, 12'hF00);  // discarded: relocking
    close_frame();
    check_outputs("relock", 6, 1'b0, 0, 0, 0);
    put_block(100, 107, 200, 207, 12'hF00);
    close_frame();
    check_outputs("after_relock", 7, 1'b1, 64, 103, 203);
  endtask

  initial begin
    test_reset();
    test_lock_and_empty();
    test_block();
    test_small_block();
    test_boundaries();
    test_corners();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/vga_marker_tracker.md
# vga_marker_tracker

Receive-side counterpart of the display pipeline: consumes a 1280x1024@60 VGA pixel stream (Hsync, Vsync, 4:4:4 RGB on the pixel clock), recovers pixel coordinates from the sync edges, and classifies each active pixel against a red-marker colour window. Per frame it builds the bounding box of matching pixels and publishes the box centre as MarkerCoord_X/Y at frame end. The output feeds the coordinate inputs of the display/game logic, so a displayed or looped-back marker can be located in closed loop.

## Interface
- H_START, 360: clocks from Hsync rising edge to first active pixel (sync 112 + back porch 248)
- V_START, 41: lines from Vsync rising edge to first active line (sync 3 + back porch 38)
- FRAME_WIDTH, 1280: active pixels per line
- FRAME_HEIGHT, 1024: active lines per frame
- RED_MIN, 4'hC: minimum red nibble for a match
- GB_MAX, 4'h3: maximum green and blue nibble for a match
- MIN_PIXELS, 16: matching pixels required to report a marker
- clk  in  1  pixel clock; sole clock domain
- reset  in  1  synchronous, active-high
- Hsync  in  1  horizontal sync, active-high, synchronous to clk
- Vsync  in  1  vertical sync, active-high, synchronous to clk
- vgaRed / vgaGreen / vgaBlue  in  4 each  pixel colour
- MarkerCoord_X  out  12  bounding-box centre X
- MarkerCoord_Y  out  12  bounding-box centre Y
- marker_found  out  1  level: last completed frame contained a marker
- frame_done  out  1  one-cycle pulse per completed frame
- pixel_count  out  21  matching pixels in last completed frame

## Operation
- All inputs registered once before use; edges detected on registered copies.
- h_cnt (12 b): cleared on Hsync rising edge, else +1, saturating at 4095. v_cnt (11 b): cleared on Vsync rising edge, +1 on each Hsync rising edge, saturating.
- Active when H_START <= h_cnt < H_START+FRAME_WIDTH and V_START <= v_cnt < V_START+FRAME_HEIGHT; X = h_cnt-H_START, Y = v_cnt-V_START.
- Match = active & red >= RED_MIN & green <= GB_MAX & blue <= GB_MAX.
- States: SYNC_WAIT (after reset; ignore stream until first Vsync rising edge) -> TRACK. In TRACK, Vsync rising edge ends a frame and starts the next; no other transitions except reset.
- Per frame accumulators: min_x/min_y init 4095, max_x/max_y init 0, cnt init 0, cnt saturates at 2^21-1. Match updates min/max/cnt in the same cycle.
- Frame end in TRACK: pixel_count <= cnt; if cnt >= MIN_PIXELS: marker_found <= 1, MarkerCoord_X <= (min_x+max_x)>>1, MarkerCoord_Y <= (min_y+max_y)>>1 (13-bit sum, truncating shift); else marker_found <= 0 and coordinates hold previous value. Accumulators reinitialised same cycle. frame_done pulses.
- Vsync edge in SYNC_WAIT: transition to TRACK, no publish, no frame_done.
- Match on the same cycle as frame end belongs to the closing frame (cannot occur with legal timing; defined for determinism).

## Timing
- Reset: all outputs 0, state SYNC_WAIT, accumulators at init values, counters 0.
- Pixel-to-match latency: 1 cycle (input register); accumulator updated at end of 2nd cycle.
- frame_done, marker_found, coordinates, pixel_count all update together 2 cycles after Vsync rises at the input pins.
- Reset asserted mid-frame: partial frame discarded; next Vsync edge only re-locks (no publish).
- Hsync/Vsync glitch-free assumed; no debounce.

## Structure
- Package vga_rx_pkg: timing constants (H_START, V_START, FRAME_WIDTH, FRAME_HEIGHT), colour-window defaults, state enum {SYNC_WAIT, TRACK}.
- Sub-module vga_rx_timing: input registers, edge detect, h_cnt/v_cnt, outputs active, X, Y, frame_edge, registered RGB. Top holds classifier, accumulators, FSM, output registers.

## Test plan
- Reset then two frames, no red -> first Vsync edge: no frame_done; second: frame_done pulse, marker_found=0, pixel_count=0, coords 0.
- 8x8 block F00 at X=100..107, Y=200..207 -> MarkerCoord_X=103, MarkerCoord_Y=203, pixel_count=64, marker_found=1.
- 3x3 block (9 px) after a valid frame -> marker_found=0, pixel_count=9, coords hold 103/203.
- Colour boundary: pixels C30 and B00 -> only C30 counted; pixel at X=1279,Y=1023 included; pixel in blanking (h_cnt=H_START-1) excluded.
- Block in corner X=0..3,Y=0..3 -> coords 1/1; block X=1276..1279 -> X=1277.
- Reset asserted mid-frame containing marker -> outputs 0; next Vsync no publish; following full frame reports correctly.
